// File: rtl/regarb_m.sv
// Two-requester register arbiter: round-robin grant, one transaction in flight to a single register target.
// Latency: accept at T, target command at T+1, response at T+3 with a zero-wait target, next grant at T+4.
// Backpressure: requester ready only in IDLE for the grantee; target and response stalls hold state. Option macro: REGARB_TIMEOUT_EN.
module regarb_m #(
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 32,
    parameter int TO_CYCLES = 255
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req0_valid,
    input  logic              i_req0_write,
    input  logic [ADDR_W-1:0] i_req0_addr,
    input  logic [DATA_W-1:0] i_req0_wdata,
    output logic              o_req0_ready,
    output logic              o_rsp0_valid,
    output logic [DATA_W-1:0] o_rsp0_rdata,
    output logic              o_rsp0_err,
    input  logic              i_rsp0_ready,
    input  logic              i_req1_valid,
    input  logic              i_req1_write,
    input  logic [ADDR_W-1:0] i_req1_addr,
    input  logic [DATA_W-1:0] i_req1_wdata,
    output logic              o_req1_ready,
    output logic              o_rsp1_valid,
    output logic [DATA_W-1:0] o_rsp1_rdata,
    output logic              o_rsp1_err,
    input  logic              i_rsp1_ready,
    output logic              o_tgt_valid,
    output logic              o_tgt_write,
    output logic [ADDR_W-1:0] o_tgt_addr,
    output logic [DATA_W-1:0] o_tgt_wdata,
    input  logic              i_tgt_ready,
    input  logic              i_tgt_rvalid,
    input  logic [DATA_W-1:0] i_tgt_rdata
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                ptr_q, ptr_d;      // 1 = requester 1 wins the next tie
    logic                gnt_q, gnt_d;      // requester owning the current transaction
    logic                write_q, write_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                grant_vld;
    logic                grant_id;
    logic                req0_rdy;
    logic                req1_rdy;
    logic                rsp_rdy;

`ifdef REGARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TO_CYCLES + 1) > 8) ? $clog2(TO_CYCLES + 1) : 8;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
`endif

    // Grant selection: a lone requester wins outright, a tie goes to the pointer.
    always_comb begin
        grant_vld = i_req0_valid | i_req1_valid;
        grant_id  = (i_req0_valid & i_req1_valid) ? ptr_q : i_req1_valid;
        rsp_rdy   = gnt_q ? i_rsp1_ready : i_rsp0_ready;
    end

    // Next-state logic for the transaction FSM and its latched fields.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gnt_d    = gnt_q;
        write_d  = write_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        req0_rdy = 1'b0;
        req1_rdy = 1'b0;
`ifdef REGARB_TIMEOUT_EN
        cnt_d    = cnt_q;
        err_d    = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (grant_vld) begin
                    // Ready goes only to the grantee, which is valid, so grant implies handshake.
                    req0_rdy = ~grant_id;
                    req1_rdy = grant_id;
                    gnt_d    = grant_id;
                    write_d  = grant_id ? i_req1_write : i_req0_write;
                    addr_d   = grant_id ? i_req1_addr  : i_req0_addr;
                    wdata_d  = grant_id ? i_req1_wdata : i_req0_wdata;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (i_tgt_ready) begin
                    state_d = S_WAIT;
`ifdef REGARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            S_WAIT: begin
                if (i_tgt_rvalid) begin
                    // A completion on the terminal timeout cycle still counts as a success.
                    rdata_d = write_q ? '0 : i_tgt_rdata;
                    state_d = S_RESP;
`ifdef REGARB_TIMEOUT_EN
                    err_d   = 1'b0;
                end else if (cnt_q == CNT_W'(TO_CYCLES - 1)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
`endif
                end
            end
            S_RESP: begin
                if (rsp_rdy) begin
                    ptr_d   = ~gnt_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register; reset drops any in-flight transaction and re-favours requester 0.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            ptr_q   <= 1'b0;
            gnt_q   <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef REGARB_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifdef REGARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    // Output decode: target command from latched fields, responses only toward the grantee.
    always_comb begin
        o_req0_ready = req0_rdy;
        o_req1_ready = req1_rdy;
        o_tgt_valid  = (state_q == S_ISSUE);
        o_tgt_write  = write_q;
        o_tgt_addr   = addr_q;
        o_tgt_wdata  = wdata_q;
        o_rsp0_valid = (state_q == S_RESP) & ~gnt_q;
        o_rsp1_valid = (state_q == S_RESP) & gnt_q;
        o_rsp0_rdata = gnt_q ? '0 : rdata_q;
        o_rsp1_rdata = gnt_q ? rdata_q : '0;
`ifdef REGARB_TIMEOUT_EN
        o_rsp0_err   = err_q & ~gnt_q;
        o_rsp1_err   = err_q & gnt_q;
`else
        o_rsp0_err   = 1'b0;
        o_rsp1_err   = 1'b0;
`endif
    end

endmodule

// File: tb/tb_regarb_m.sv
// Bench for regarb_m: directed requests, scoreboard queue of expected responses, monitor pops on handshake.
// Latency: checks the T+1 command / T+3 response timing and timeout exit when REGARB_TIMEOUT_EN is set.
// Backpressure: exercises target-ready stalls, response-ready stalls and reset during WAIT.
module tb_regarb_m;

    typedef struct packed {
        logic        port;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [1:0]  rv;
    logic [1:0]  rw;
    logic [3:0]  ra [2];
    logic [31:0] rd [2];
    logic [1:0]  rdy;
    logic [1:0]  rspv;
    logic [31:0] rsp_rdata [2];
    logic [1:0]  rsp_err;
    logic [1:0]  rsp_rdy;
    logic        tgt_valid;
    logic        tgt_write;
    logic [3:0]  tgt_addr;
    logic [31:0] tgt_wdata;
    logic        tgt_ready;
    logic        tgt_rvalid;
    logic [31:0] tgt_rdata;
    logic [31:0] mem [16];

    exp_t exp_q[$];
    int   checks;
    int   failures;

`ifdef REGARB_TIMEOUT_EN
    regarb_m #(.ADDR_W(4), .DATA_W(32), .TO_CYCLES(16)) dut (
`else
    regarb_m #(.ADDR_W(4), .DATA_W(32)) dut (
`endif
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req0_valid (rv[0]),
        .i_req0_write (rw[0]),
        .i_req0_addr  (ra[0]),
        .i_req0_wdata (rd[0]),
        .o_req0_ready (rdy[0]),
        .o_rsp0_valid (rspv[0]),
        .o_rsp0_rdata (rsp_rdata[0]),
        .o_rsp0_err   (rsp_err[0]),
        .i_rsp0_ready (rsp_rdy[0]),
        .i_req1_valid (rv[1]),
        .i_req1_write (rw[1]),
        .i_req1_addr  (ra[1]),
        .i_req1_wdata (rd[1]),
        .o_req1_ready (rdy[1]),
        .o_rsp1_valid (rspv[1]),
        .o_rsp1_rdata (rsp_rdata[1]),
        .o_rsp1_err   (rsp_err[1]),
        .i_rsp1_ready (rsp_rdy[1]),
        .o_tgt_valid  (tgt_valid),
        .o_tgt_write  (tgt_write),
        .o_tgt_addr   (tgt_addr),
        .o_tgt_wdata  (tgt_wdata),
        .i_tgt_ready  (tgt_ready),
        .i_tgt_rvalid (tgt_rvalid),
        .i_tgt_rdata  (tgt_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register target model: mem[3]=0xA5, others 0xC0DE_000<addr>, reinitialised while reset is high.
    assign tgt_rdata = mem[tgt_addr];
    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) mem[i] <= (i == 3) ? 32'h0000_00A5 : (32'hC0DE_0000 | i);
        end else if (tgt_valid && tgt_ready && tgt_write) begin
            mem[tgt_addr] <= tgt_wdata;
        end
    end

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endfunction

    function automatic logic [143:0] all_outs();
        return {tgt_valid, tgt_write, tgt_addr, tgt_wdata, rdy, rspv,
                rsp_rdata[0], rsp_rdata[1], rsp_err};
    endfunction

    // Monitor: every response handshake pops one expectation; exclusivity checked each cycle.
    always @(negedge clk) begin
        if (!rst) begin
            chk("rsp_exclusive", {63'd0, rspv == 2'b11}, 64'd0);
            for (int p = 0; p < 2; p++) begin
                if (rspv[p] && rsp_rdy[p]) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_rsp_port", 64'(p), 64'hFFFF);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("rsp_port",  64'(p), {63'd0, e.port});
                        chk("rsp_rdata", {32'd0, rsp_rdata[p]}, {32'd0, e.rdata});
                        chk("rsp_err",   {63'd0, rsp_err[p]}, {63'd0, e.err});
                    end
                end
            end
        end
    end

    task automatic expect_rsp(input logic p, input logic [31:0] d, input logic e);
        exp_t x;
        x.port  = p;
        x.rdata = d;
        x.err   = e;
        exp_q.push_back(x);
    endtask

    // Present one request and hold it until the arbiter accepts it.
    task automatic req(input int p, input logic wr, input logic [3:0] a, input logic [31:0] d);
        bit got;
        got = 0;
        @(posedge clk); #1;
        rv[p] = 1'b1; rw[p] = wr; ra[p] = a; rd[p] = d;
        for (int n = 0; n < 300 && !got; n++) begin
            @(negedge clk);
            if (rdy[p]) got = 1;
        end
        @(posedge clk); #1;
        rv[p] = 1'b0;
        chk($sformatf("req%0d_accepted", p), {63'd0, got}, 64'd1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 200 && exp_q.size() != 0; n++) @(negedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1; rv = 2'b00; rw = 2'b00;
        ra[0] = 4'd0; ra[1] = 4'd0; rd[0] = 32'd0; rd[1] = 32'd0;
        rsp_rdy = 2'b11; tgt_ready = 1'b1; tgt_rvalid = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {63'd0, all_outs() != 144'd0}, 64'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Single read, zero-wait target: latency T+1 command, T+3 response
        expect_rsp(1'b0, 32'h0000_00A5, 1'b0);
        @(posedge clk); #1;
        rv[0] = 1'b1; rw[0] = 1'b0; ra[0] = 4'd3;
        @(negedge clk); chk("lat_ready_T", {63'd0, rdy[0]}, 64'd1);
        chk("lat_ready1_T", {63'd0, rdy[1]}, 64'd0);
        @(posedge clk); #1 rv[0] = 1'b0;
        @(negedge clk); chk("lat_tgt_valid_T1", {63'd0, tgt_valid}, 64'd1);
        chk("lat_tgt_addr_T1", {60'd0, tgt_addr}, 64'd3);
        @(negedge clk); chk("lat_rsp_T2", {62'd0, rspv}, 64'd0);
        @(negedge clk); chk("lat_rsp_T3", {62'd0, rspv}, 64'd1);
        @(negedge clk); chk("lat_idle_T4", {62'd0, rspv}, 64'd0);
        drain();

        // Simultaneous requests after reset: strict alternation 0,1,0,1
        do_reset();
        expect_rsp(1'b0, 32'hC0DE_0001, 1'b0);
        expect_rsp(1'b1, 32'hC0DE_0002, 1'b0);
        expect_rsp(1'b0, 32'hC0DE_0004, 1'b0);
        expect_rsp(1'b1, 32'hC0DE_0008, 1'b0);
        fork
            begin req(0, 1'b0, 4'd1, 32'd0); req(0, 1'b0, 4'd4, 32'd0); end
            begin req(1, 1'b0, 4'd2, 32'd0); req(1, 1'b0, 4'd8, 32'd0); end
        join
        drain();

        // Write with stalled target: command fields held stable, write returns 0
        expect_rsp(1'b1, 32'h0000_0000, 1'b0);
        tgt_ready = 1'b0;
        req(1, 1'b1, 4'd7, 32'h1234_5678);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("stall_tgt_cmd_%0d", i), {tgt_valid, tgt_write, 22'd0, tgt_addr, tgt_wdata},
                {1'b1, 1'b1, 22'd0, 4'd7, 32'h1234_5678});
        end
        @(posedge clk); #1 tgt_ready = 1'b1;
        drain();
        expect_rsp(1'b0, 32'h1234_5678, 1'b0);
        req(0, 1'b0, 4'd7, 32'd0);
        drain();

        // Response held 10 cycles; the other requester stays blocked meanwhile
        expect_rsp(1'b0, 32'h0000_00A5, 1'b0);
        expect_rsp(1'b1, 32'h0000_0000, 1'b0);
        rsp_rdy[0] = 1'b0;
        req(0, 1'b0, 4'd3, 32'd0);
        fork
            req(1, 1'b1, 4'd9, 32'hDEAD_0009);
            begin
                for (int n = 0; n < 20 && !rspv[0]; n++) @(negedge clk);
                for (int i = 0; i < 10; i++) begin
                    chk($sformatf("hold_rsp0_%0d", i), {rspv, rdy, rsp_rdata[0]}, {2'b01, 2'b00, 32'h0000_00A5});
                    @(negedge clk);
                end
                @(posedge clk); #1 rsp_rdy[0] = 1'b1;
            end
        join
        drain();

        // Reset during WAIT discards the transaction and re-favours requester 0
        expect_rsp(1'b0, 32'hC0DE_000B, 1'b0);
        req(0, 1'b0, 4'd11, 32'd0);
        drain();
        tgt_rvalid = 1'b0;
        req(1, 1'b0, 4'd5, 32'd0);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_wait_outputs", {63'd0, all_outs() != 144'd0}, 64'd0);
        tgt_rvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("rst_no_rsp_%0d", i), {61'd0, tgt_valid, rspv}, 64'd0);
        end
        expect_rsp(1'b0, 32'hC0DE_0006, 1'b0);
        expect_rsp(1'b1, 32'hC0DE_000A, 1'b0);
        fork
            req(0, 1'b0, 4'd6, 32'd0);
            req(1, 1'b0, 4'd10, 32'd0);
        join
        drain();

`ifdef REGARB_TIMEOUT_EN
        // Timeout after 16 WAIT cycles with no completion
        expect_rsp(1'b1, 32'h0000_0000, 1'b1);
        tgt_rvalid = 1'b0;
        req(1, 1'b0, 4'd2, 32'd0);
        repeat (16) @(posedge clk);
        @(negedge clk); chk("to_not_yet", {62'd0, rspv}, 64'd0);
        @(negedge clk); chk("to_fired", {62'd0, rspv}, 64'd2);
        drain();

        // Completion on the terminal cycle wins over the timeout
        expect_rsp(1'b1, 32'hC0DE_0002, 1'b0);
        req(1, 1'b0, 4'd2, 32'd0);
        repeat (16) @(posedge clk);
        #1 tgt_rvalid = 1'b1;
        @(posedge clk); #1 tgt_rvalid = 1'b0;
        @(negedge clk); chk("to_terminal_rvalid", {62'd0, rspv}, 64'd2);
        drain();
        tgt_rvalid = 1'b1;
`endif

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
